// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// Contents: FSM state type, operation codes, default operand width.
// Optional feature macro: MULDIV_SDIV_EN (signed divide on op 2'b10).
package muldiv_pkg;

    localparam int unsigned N_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_UDIV = 2'b01;
    localparam logic [1:0] OP_SDIV = 2'b10;

endpackage

// File: rtl/muldiv_datapath.sv
// Iteration registers for the multiply/divide sequencer: shift-add multiply
// and restoring divide, one bit per step.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load           latch operands/op (one cycle, on accept)
//   step           perform one iteration
//   op, op_a, op_b operation code and operands
//   result         final value (product low word, quotient, or 0 on /0)
//   div_zero       latched: divide with zero divisor
// Optional feature macro: MULDIV_SDIV_EN (magnitude conversion + sign fix-up).
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [1:0]   op,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic [N-1:0] result,
    output logic         div_zero
);

    // a: multiplicand (MUL) or dividend shifting into quotient (DIV)
    // b: multiplier (MUL) or divisor (DIV)
    logic [N-1:0] a, b, acc, rem;
    logic         is_div;
    logic         is_div_in;
    logic [N-1:0] a_in, b_in, quot;
    logic [N:0]   rem_sh;
    logic         rem_ge;

    assign is_div_in = (op == OP_UDIV) || (op == OP_SDIV);

`ifdef MULDIV_SDIV_EN
    logic neg, neg_in, is_sdiv_in;
    assign is_sdiv_in = (op == OP_SDIV);
    assign a_in   = (is_sdiv_in && op_a[N-1]) ? -op_a : op_a;
    assign b_in   = (is_sdiv_in && op_b[N-1]) ? -op_b : op_b;
    assign neg_in = is_sdiv_in && (op_a[N-1] ^ op_b[N-1]);
    assign quot   = neg ? -a : a;
`else
    assign a_in = op_a;
    assign b_in = op_b;
    assign quot = a;
`endif

    // Remainder is kept one bit wider during the shift so divisors with the
    // MSB set still compare correctly.
    assign rem_sh = {rem, a[N-1]};
    assign rem_ge = rem_sh >= {1'b0, b};
    assign result = !is_div ? acc : (div_zero ? '0 : quot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a        <= '0;
            b        <= '0;
            acc      <= '0;
            rem      <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
`ifdef MULDIV_SDIV_EN
            neg      <= 1'b0;
`endif
        end else if (load) begin
            a        <= a_in;
            b        <= b_in;
            acc      <= '0;
            rem      <= '0;
            is_div   <= is_div_in;
            div_zero <= is_div_in && (op_b == '0);
`ifdef MULDIV_SDIV_EN
            neg      <= neg_in;
`endif
        end else if (step) begin
            if (is_div) begin
                rem <= rem_ge ? (rem_sh[N-1:0] - b) : rem_sh[N-1:0];
                a   <= {a[N-2:0], rem_ge};
            end else begin
                if (b[0]) acc <= acc + a;
                a <= a << 1;
                b <= b >> 1;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multi-cycle MUL/UDIV(/SDIV) unit beside the execute-stage ALU.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start_E, op_E       request and operation (sampled only in IDLE)
//   opA_E, opB_E        operands
//   flush_E             abort; forces IDLE on the next edge
//   stall_E             holds the pipeline while the unit is occupied
//   busy                state != IDLE
//   done                one-cycle pulse, result_E valid
//   result_E            product/quotient, held until the next completion
// Optional feature macro: MULDIV_SDIV_EN (op 2'b10 as signed divide).
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_E,
    input  logic [1:0]   op_E,
    input  logic [N-1:0] opA_E,
    input  logic [N-1:0] opB_E,
    input  logic         flush_E,
    output logic         stall_E,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result_E
);

    localparam int unsigned CNT_W = $clog2(N);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [N-1:0]     result_q, dp_result;
    logic             load, step, div_zero;

    muldiv_datapath #(.N(N)) u_datapath (
        .clk      (clk),
        .rst      (reset),
        .load     (load),
        .step     (step),
        .op       (op_E),
        .op_a     (opA_E),
        .op_b     (opB_E),
        .result   (dp_result),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (load)
                count <= CNT_W'(N - 1);
            else if (state == RUN)
                count <= count - CNT_W'(1);
            if (state == DONE && !flush_E)
                result_q <= dp_result;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        stall_E   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                stall_E = start_E & ~flush_E;
                if (start_E && !flush_E) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                stall_E = 1'b1;
                step    = 1'b1;
                if (flush_E)
                    state_nxt = IDLE;
                else if (count == '0 || div_zero)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = ~flush_E;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    // The completing value is visible during the DONE cycle itself; a flush
    // in that cycle leaves the previously held result on the output.
    assign result_E = (state == DONE && !flush_E) ? dp_result : result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: timeline model plus literal checks.
module tb_muldiv_sequencer;
    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset, start_E, flush_E;
    logic [1:0]   op_E;
    logic [N-1:0] opA_E, opB_E;
    logic         stall_E, busy, done;
    logic [N-1:0] result_E;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: an accepted op occupies the unit until done_cyc (-1 = idle).
    int           done_cyc = -1;
    logic [N-1:0] pending = '0;
    logic [N-1:0] last_result = '0;
    bit           model_on = 1'b0;

    muldiv_sequencer #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_E  (start_E),
        .op_E     (op_E),
        .opA_E    (opA_E),
        .opB_E    (opB_E),
        .flush_E  (flush_E),
        .stall_E  (stall_E),
        .busy     (busy),
        .done     (done),
        .result_E (result_E)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] model_calc(logic [1:0] op, logic [N-1:0] a, logic [N-1:0] b);
        logic [N-1:0] minv;
        minv = '0;
        minv[N-1] = 1'b1;
        if (op == 2'b01 || op == 2'b10) begin
            if (b == '0) return '0;
`ifdef MULDIV_SDIV_EN
            if (op == 2'b10) begin
                if (a == minv && b == '1) return minv;
                return N'($signed(a) / $signed(b));
            end
`endif
            return a / b;
        end
        return a * b;
    endfunction

    task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            done_cyc    = -1;
            last_result = '0;
        end else if (model_on) begin
            bit b_exp, d_exp, s_exp, is_div;
            b_exp = (done_cyc != -1);
            d_exp = b_exp && (cyc == done_cyc) && !flush_E;
            s_exp = b_exp ? (cyc != done_cyc) : (start_E && !flush_E);
            check("busy", N'(busy), N'(b_exp));
            check("done", N'(done), N'(d_exp));
            check("stall", N'(stall_E), N'(s_exp));
            check("result", result_E, d_exp ? pending : last_result);
            if (flush_E) begin
                done_cyc = -1;
            end else if (!b_exp && start_E) begin
                is_div   = (op_E == 2'b01) || (op_E == 2'b10);
                done_cyc = cyc + ((is_div && opB_E == '0) ? 2 : N + 1);
                pending  = model_calc(op_E, opA_E, opB_E);
            end else if (b_exp && cyc == done_cyc) begin
                last_result = pending;
                done_cyc    = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic [1:0] op, logic [N-1:0] a, logic [N-1:0] b, output int t_acc);
        start_E = 1'b1;
        op_E    = op;
        opA_E   = a;
        opB_E   = b;
        t_acc   = cyc;
        tick();
        start_E = 1'b0;
    endtask

    // Returns in the cycle after done; bounded so a stuck unit cannot hang.
    task automatic wait_done(output int t_done);
        bit seen;
        seen   = 1'b0;
        t_done = -1;
        for (int i = 0; i < 2 * N + 10; i++) begin
            @(negedge clk);
            if (done) begin
                t_done = cyc;
                seen   = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", 2 * N + 10);
        end
        tick();
    endtask

    task automatic run_op(string name, logic [1:0] op, logic [N-1:0] a, logic [N-1:0] b,
                          logic [N-1:0] exp, int exp_lat);
        int ta, td;
        issue(op, a, b, ta);
        wait_done(td);
        check({name, "_latency"}, N'(td - ta), N'(exp_lat));
        check({name, "_value"}, result_E, exp);
    endtask

    initial begin
        int ta, td, td1;
        reset = 1'b1; start_E = 1'b0; flush_E = 1'b0;
        op_E = 2'b00; opA_E = '0; opB_E = '0;
        tick(); tick();
        check("rst_busy", N'(busy), '0);
        check("rst_done", N'(done), '0);
        check("rst_stall", N'(stall_E), '0);
        check("rst_result", result_E, '0);
        reset = 1'b0;
        model_on = 1'b1;
        tick();

        run_op("udiv_100_7", 2'b01, 64'd100, 64'd7, 64'd14, 65);
        run_op("udiv_max_1", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("udiv_big_divisor", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, 65);
        run_op("udiv_5_0", 2'b01, 64'd5, 64'd0, 64'd0, 2);
        run_op("op11_mul", 2'b11, 64'd3, 64'd5, 64'd15, 65);
        run_op("mul_7_6", 2'b00, 64'd7, 64'd6, 64'd42, 65);
        check("mul_idle_after", N'(busy), '0);

        // Flush in RUN cycle 10 of MUL 3x3.
        issue(2'b00, 64'd3, 64'd3, ta);
        while (cyc < ta + 10) tick();
        flush_E = 1'b1;
        tick();
        flush_E = 1'b0;
        check("flush_busy", N'(busy), '0);
        check("flush_result", result_E, 64'd42);
        repeat (N + 4) tick();
        check("flush_no_late_result", result_E, 64'd42);

        // start_E held high across two back-to-back MULs.
        start_E = 1'b1; op_E = 2'b00; opA_E = 64'd5; opB_E = 64'd9; ta = cyc;
        wait_done(td1);
        check("b2b_first_latency", N'(td1 - ta), 64'd65);
        check("b2b_first_value", result_E, 64'd45);
        opA_E = 64'd11; opB_E = 64'd13;
        tick();
        start_E = 1'b0;
        wait_done(td);
        check("b2b_second_latency", N'(td - td1), 64'd66);
        check("b2b_second_value", result_E, 64'd143);

        // Asynchronous reset between edges, mid-RUN.
        issue(2'b00, 64'd7, 64'd6, ta);
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", N'(busy), '0);
        check("arst_stall", N'(stall_E), '0);
        check("arst_done", N'(done), '0);
        check("arst_result", result_E, '0);
        @(negedge clk);
        tick();
        reset = 1'b0;
        tick();

`ifdef MULDIV_SDIV_EN
        run_op("sdiv_m100_7", 2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        run_op("sdiv_ovf", 2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 65);
        run_op("sdiv_zero", 2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'd0, 64'd0, 2);
`else
        run_op("op10_udiv", 2'b10, 64'd100, 64'd7, 64'd14, 65);
`endif
        run_op("post_mul", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multi-cycle multiply/divide sequencer beside the execute-stage ALU. Handles LEGv8 MUL and UDIV (and SDIV optionally), which the single-cycle ALU cannot execute.
- Accepts an operation from decode/execute and raises a stall toward the pipeline while busy. Delivers one result word with a done pulse, which the EX/MEM writeback mux selects instead of aluResult_E.
- Runs a shift-add multiply or a restoring divide, one bit per cycle.

Parameters:
- N, 64, operand/result width in bits (power of 2, >= 8).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_E  input  1  request a new operation; sampled only in IDLE.
- op_E  input  2  operation: 2'b00 MUL (low N bits of unsigned product), 2'b01 UDIV, 2'b10 SDIV (see Optional Feature), 2'b11 reserved (treated as MUL).
- opA_E  input  N  multiplicand / dividend (readData1_E).
- opB_E  input  N  multiplier / divisor (readData2_E).
- flush_E  input  1  abort the in-flight operation (branch mispredict / exception).
- stall_E  output  1  freezes PC, IF/ID and ID/EX while the unit is occupied.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse; result is valid this cycle.
- result_E  output  N  product or quotient; holds its value until the next accepted start.

Behaviour:
- FSM states: IDLE, RUN, DONE. State is encoded in a 2-bit enum.
- Reset (asynchronous): state = IDLE; count = 0; result_E = 0; done = 0; busy = 0; internal accumulator, quotient and remainder registers = 0.
- IDLE:
  - On start_E=1 and flush_E=0, latch opA/opB/op, set count = N-1, go to RUN.
  - stall_E = start_E & ~flush_E (combinational), so the instruction is held in ID/EX from the first cycle.
- RUN:
  - Performs one iteration per cycle. Count decrements each cycle; when count==0, go to DONE after that iteration.
  - stall_E = 1 and busy = 1 in every RUN cycle.
  - MUL iteration: if B[0], acc += A; A <<= 1; B >>= 1. All arithmetic is mod 2^N.
  - UDIV iteration (restoring): rem = {rem[N-2:0], Q[N-1]}; Q <<= 1; if rem >= divisor then rem -= divisor and Q[0] = 1.
- DONE:
  - Lasts exactly one cycle: result_E <= acc or Q, done = 1, stall_E = 0, busy = 1.
  - Next state is IDLE. start_E is not accepted in DONE.
  - Latency: a start accepted at cycle t gives done=1 at cycle t+N+1.
- Divide by zero: opB_E==0 skips iteration. The unit goes RUN then DONE after 1 cycle with result_E = 0 (ARMv8 semantics). stall_E behaves as usual for that cycle.
- start_E while RUN or DONE is ignored; the requester stays stalled and re-presents the request.
- flush_E:
  - In any state, flush_E forces IDLE on the next edge. done is not asserted and result_E keeps its old value.
  - flush_E has priority over start_E and over the count==0 transition.
  - Flush in the DONE cycle suppresses the done pulse.
- Simultaneous start_E and flush_E in IDLE: the request is dropped.

Optional Feature:
- Macro: MULDIV_SDIV_EN.
- Defined:
  - op 2'b10 is signed divide. Operands are converted to magnitudes on accept.
  - Quotient is negated in DONE if the sign bits of opA and opB differ; truncation is toward zero.
  - Overflow case (most negative value / -1) yields the most negative value.
  - Divide by zero yields 0.
- Undefined: op 2'b10 is executed as UDIV. No sign logic is synthesised.

Decomposition:
- Shared package muldiv_pkg:
  - typedef enum state_t {IDLE, RUN, DONE}.
  - op codes OP_MUL, OP_UDIV, OP_SDIV.
  - localparam CNT_W = $clog2(N).
- One natural sub-module: muldiv_datapath (iteration registers and add/subtract/compare). The FSM, counter and stall logic stay in muldiv_sequencer.

Test Plan:
- MUL 7 x 6, start for 1 cycle: stall_E high for 65 cycles, done at t+65, result_E = 42, busy low at t+66.
- UDIV 100 / 7: result_E = 14. UDIV 0xFFFF_FFFF_FFFF_FFFF / 1 returns the dividend unchanged.
- UDIV 5 / 0: done at t+2, result_E = 0, no hang.
- Flush at RUN cycle 10 of MUL 3 x 3: next cycle IDLE, no done, result_E keeps the previous value (42).
- start_E held high continuously with back-to-back MULs: the second operation is accepted only in the IDLE cycle after DONE, and both results are correct.
- Reset asserted mid-RUN (asynchronous, between edges): outputs go to 0 immediately. With MULDIV_SDIV_EN, SDIV -100 / 7 after release gives -14.
